// File: rtl/avalon_slave_data_mem_if.sv
// ============================================================================
//  Module   : avalon_slave_data_mem_if
//  Purpose  : Avalon-MM data-port bundle between the core's data master and
//             the data-memory slave.
//  Signals  : avs_address     word address (ADDR_W bits)
//             avs_read        read request
//             avs_write       write request
//             avs_writedata   32-bit write data
//             avs_byteenable  bit i enables byte i
//             avs_readdata    32-bit read data, valid in the ACK cycle
//             avs_waitrequest high while the transfer is not yet accepted
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface avalon_slave_data_mem_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/avalon_slave_data_mem.sv
// ============================================================================
//  Module   : avalon_slave_data_mem
//  Purpose  : Avalon-MM slave data memory with byte enables, fixed wait
//             states and a sticky end-of-test mailbox flag.
//  Ports    : clk       single clock, rising edge
//             reset_n   asynchronous active-low reset
//             avs       slave side of the Avalon-MM data-port bundle
//             sim_done  sticky; mailbox word received HALT_VALUE
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_slave_data_mem #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter int          HALT_ADDR   = 1023,
  parameter logic [31:0] HALT_VALUE  = 32'd7777
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_slave_data_mem_if.slave  avs,
  output logic                    sim_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Entering WAIT already accounts for the IDLE cycle and the final WAIT
  // cycle that sees cnt==0, hence the -2.
  localparam logic [3:0]        CNT_INIT   = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;
  localparam logic [ADDR_W-1:0] HALT_WADDR = ADDR_W'(HALT_ADDR);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        done_q;
  logic [31:0] mem_q [2**ADDR_W];

  logic        req;
  logic        load_rd;
  logic        commit;
  logic [31:0] merged;

  assign req = avs.avs_read | avs.avs_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A master dropping its request mid-transfer abandons it entirely.
        if (!req)               state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_ACK;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is captured on the edge into ACK; a simultaneous write wins.
  assign load_rd = (state_d == S_ACK) && (state_q != S_ACK) &&
                   avs.avs_read && !avs.avs_write;
  assign commit  = (state_q == S_ACK) && avs.avs_write;

  always_comb begin
    merged = mem_q[avs.avs_address];
    for (int i = 0; i < 4; i++) begin
      if (avs.avs_byteenable[i]) merged[8*i +: 8] = avs.avs_writedata[8*i +: 8];
    end
  end

  // Storage is deliberately not reset. An async reset during ACK has already
  // forced state_q to IDLE, so an interrupted write never commits.
  always_ff @(posedge clk) begin
    if (commit) mem_q[avs.avs_address] <= merged;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_rd) rdata_q <= mem_q[avs.avs_address];
      // A zero byte-enable write commits nothing, so it cannot halt either.
      if (commit && (avs.avs_address == HALT_WADDR) && (|avs.avs_byteenable) &&
          (merged == HALT_VALUE))
        done_q <= 1'b1;
    end
  end

  assign avs.avs_readdata    = rdata_q;
  assign avs.avs_waitrequest = req && (state_q != S_ACK);
  assign sim_done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_avalon_slave_data_mem.sv
// ============================================================================
//  Module   : tb_avalon_slave_data_mem
//  Purpose  : Self-checking bench for avalon_slave_data_mem. Two instances:
//             u_dut3 with three wait states, u_dut1 with one.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_avalon_slave_data_mem;

  localparam int          WC3  = 3;
  localparam int          WC1  = 1;
  localparam logic [9:0]  HALT = 10'd1023;
  localparam logic [31:0] HVAL = 32'd7777;

  logic clk = 1'b0;
  logic reset_n;
  logic sim_done3, sim_done1;

  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd3, wr3, rd1, wr1;

  always #5 clk = ~clk;

  avalon_slave_data_mem_if #(.ADDR_W(10)) bus3 ();
  avalon_slave_data_mem_if #(.ADDR_W(10)) bus1 ();

  assign bus3.avs_address    = addr;
  assign bus3.avs_writedata  = wdata;
  assign bus3.avs_byteenable = be;
  assign bus3.avs_read       = rd3;
  assign bus3.avs_write      = wr3;
  assign bus1.avs_address    = addr;
  assign bus1.avs_writedata  = wdata;
  assign bus1.avs_byteenable = be;
  assign bus1.avs_read       = rd1;
  assign bus1.avs_write      = wr1;

  avalon_slave_data_mem #(.ADDR_W(10), .WAIT_CYCLES(WC3), .HALT_ADDR(1023), .HALT_VALUE(32'd7777))
    u_dut3 (.clk(clk), .reset_n(reset_n), .avs(bus3), .sim_done(sim_done3));
  avalon_slave_data_mem #(.ADDR_W(10), .WAIT_CYCLES(WC1), .HALT_ADDR(1023), .HALT_VALUE(32'd7777))
    u_dut1 (.clk(clk), .reset_n(reset_n), .avs(bus1), .sim_done(sim_done1));

  // Reference model: contents, which words are fully known, last read data,
  // and the sticky done flag, one set per instance.
  logic [31:0] m3 [1024];
  logic [31:0] m1 [1024];
  bit          v3 [1024];
  bit          v1 [1024];
  logic [31:0] ref_rd3, ref_rd1;
  logic        ref_done3, ref_done1;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic wreq(input int sel);
    return (sel == 3) ? bus3.avs_waitrequest : bus1.avs_waitrequest;
  endfunction

  function automatic logic [31:0] rdat_of(input int sel);
    return (sel == 3) ? bus3.avs_readdata : bus1.avs_readdata;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One full transfer, entered and left at posedge+1. Counts waitrequest-high
  // cycles and captures readdata in the ACK cycle.
  task automatic xfer(input int sel, input logic r, input logic w, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rdat, output int nwait);
    addr = a; wdata = d; be = b;
    if (sel == 3) begin rd3 = r; wr3 = w; end
    else          begin rd1 = r; wr1 = w; end
    nwait = 0;
    rdat  = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wreq(sel)) nwait++;
      else begin
        rdat = rdat_of(sel);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd3 = 1'b0; wr3 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  // Transfer plus model update and the checks that follow every transfer.
  task automatic op(input int sel, input logic r, input logic w, input logic [9:0] a,
                    input logic [31:0] d, input logic [3:0] b);
    logic [31:0] rdat, old, nw;
    int          nwait;
    bit          known;
    xfer(sel, r, w, a, d, b, rdat, nwait);
    check("waits", 32'(nwait), (sel == 3) ? 32'(WC3) : 32'(WC1));
    old   = (sel == 3) ? m3[a] : m1[a];
    known = (sel == 3) ? v3[a] : v1[a];
    if (w) begin
      nw = merge(old, d, b);
      if (sel == 3) begin m3[a] = nw; v3[a] = known || (b == 4'hF); end
      else          begin m1[a] = nw; v1[a] = known || (b == 4'hF); end
      if (a == HALT && b != 4'h0 && (known || b == 4'hF) && nw == HVAL) begin
        if (sel == 3) ref_done3 = 1'b1; else ref_done1 = 1'b1;
      end
    end else if (r && known) begin
      check("rdata_ack", rdat, old);
      if (sel == 3) ref_rd3 = old; else ref_rd1 = old;
    end
    check("rdata_hold", rdat_of(sel), (sel == 3) ? ref_rd3 : ref_rd1);
    check("sim_done", {31'd0, (sel == 3) ? sim_done3 : sim_done1},
          {31'd0, (sel == 3) ? ref_done3 : ref_done1});
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] d;
    int          kind;
    bit          ack_seen;

    for (int i = 0; i < 1024; i++) begin v3[i] = 0; v1[i] = 0; end
    ref_rd3 = '0; ref_rd1 = '0; ref_done3 = 1'b0; ref_done1 = 1'b0;
    addr = '0; wdata = '0; be = '0;
    rd3 = 1'b1; wr3 = 1'b0; rd1 = 1'b1; wr1 = 1'b0;
    reset_n = 1'b0;

    // Reset held with a read pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wreq3", {31'd0, bus3.avs_waitrequest}, 32'd1);
    check("rst_wreq1", {31'd0, bus1.avs_waitrequest}, 32'd1);
    check("rst_rdata3", bus3.avs_readdata, 32'd0);
    check("rst_rdata1", bus1.avs_readdata, 32'd0);
    check("rst_done3", {31'd0, sim_done3}, 32'd0);
    @(posedge clk); #1;
    rd3 = 1'b0; rd1 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_wreq3", {31'd0, bus3.avs_waitrequest}, 32'd0);
    @(posedge clk); #1;

    // Single-wait-state instance: directed then random.
    op(1, 0, 1, 10'd2, 32'h12345678, 4'hF);
    op(1, 1, 0, 10'd2, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) op(1, 0, 1, 10'(40 + i), $urandom, 4'hF);
    for (int i = 0; i < 12; i++) begin
      a = 10'(40 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) op(1, 1, 0, a, 32'h0, 4'hF);
      else op(1, 0, 1, a, $urandom, 4'($urandom));
    end

    // Full write then read.
    op(3, 0, 1, 10'd5, 32'hDEADBEEF, 4'hF);
    op(3, 1, 0, 10'd5, 32'h0, 4'hF);
    check("deadbeef", bus3.avs_readdata, 32'hDEADBEEF);

    // Byte enables.
    op(3, 0, 1, 10'd7, 32'h11223344, 4'hF);
    op(3, 0, 1, 10'd7, 32'hAABBCCDD, 4'b0101);
    op(3, 1, 0, 10'd7, 32'h0, 4'hF);
    check("be_merge", bus3.avs_readdata, 32'h11BB33DD);
    op(3, 0, 1, 10'd7, 32'hFFFFFFFF, 4'h0);
    op(3, 1, 0, 10'd7, 32'h0, 4'hF);

    // Random traffic over a fully initialised window.
    for (int i = 16; i < 32; i++) op(3, 0, 1, 10'(i), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      a    = 10'(16 + $urandom_range(0, 15));
      kind = $urandom_range(0, 2);
      d    = $urandom;
      case (kind)
        0:       op(3, 1, 0, a, d, 4'hF);
        1:       op(3, 0, 1, a, d, 4'($urandom));
        default: op(3, 1, 1, a, d, 4'($urandom));
      endcase
    end

    // Simultaneous read and write is a write.
    op(3, 0, 1, 10'd3, 32'hCAFEF00D, 4'hF);
    op(3, 1, 0, 10'd5, 32'h0, 4'hF);
    op(3, 1, 1, 10'd3, 32'h5, 4'hF);
    check("rw_hold", bus3.avs_readdata, 32'hDEADBEEF);
    op(3, 1, 0, 10'd3, 32'h0, 4'hF);
    check("rw_read", bus3.avs_readdata, 32'h5);

    // Mailbox neighbour and partial merge into the mailbox.
    op(3, 0, 1, HALT - 10'd1, 32'd7776, 4'hF);
    op(3, 0, 1, HALT - 10'd1, HVAL, 4'hF);
    check("neighbour", {31'd0, sim_done3}, 32'd0);
    op(3, 0, 1, HALT, 32'h00001E00, 4'hF);
    op(3, 0, 1, HALT, 32'hFFFFFF61, 4'b0001);
    check("partial_halt", {31'd0, sim_done3}, 32'd1);
    op(3, 0, 1, HALT, 32'd0, 4'hF);
    check("sticky", {31'd0, sim_done3}, 32'd1);

    // Request dropped during WAIT: nothing committed.
    op(3, 0, 1, 10'd9, 32'h0BADF00D, 4'hF);
    addr = 10'd9; wdata = 32'h99999999; be = 4'hF; wr3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr3 = 1'b0;
    @(negedge clk);
    check("abort_wreq", {31'd0, bus3.avs_waitrequest}, 32'd0);
    @(posedge clk); #1;
    op(3, 1, 0, 10'd9, 32'h0, 4'hF);

    // Reset asserted in the ACK cycle of a write.
    op(3, 0, 1, 10'd10, 32'h10101010, 4'hF);
    addr = 10'd10; wdata = 32'h55AA55AA; be = 4'hF; wr3 = 1'b1;
    ack_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus3.avs_waitrequest) begin ack_seen = 1; break; end
    end
    check("ack_seen", {31'd0, ack_seen}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstack_rdata", bus3.avs_readdata, 32'd0);
    check("rstack_done", {31'd0, sim_done3}, 32'd0);
    @(posedge clk); #1;
    wr3 = 1'b0;
    reset_n = 1'b1;
    ref_rd3 = '0; ref_rd1 = '0; ref_done3 = 1'b0; ref_done1 = 1'b0;
    @(posedge clk); #1;
    op(3, 1, 0, 10'd10, 32'h0, 4'hF);
    check("no_commit", bus3.avs_readdata, 32'h10101010);

    // Full-word sentinel write.
    op(3, 0, 1, HALT, HVAL, 4'hF);
    check("halt_full", {31'd0, sim_done3}, 32'd1);
    op(3, 0, 1, HALT, 32'd0, 4'hF);
    check("halt_sticky", {31'd0, sim_done3}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
